// File: rtl/flappy_pkg.sv
// Shared state encoding, key codes, geometry defaults and LFSR helper for the
// flappy-bird game controller.
package flappy_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DEAD = 2'b10
   } state_t;

   localparam logic [7:0] KEY_START   = 8'h51;
   localparam logic [7:0] KEY_RESTART = 8'h57;
   localparam logic [7:0] KEY_FLAP    = 8'h45;

   localparam int unsigned DEF_TICK_DIV  = 250000;
   localparam int unsigned DEF_BIRD_X    = 100;
   localparam int unsigned DEF_BIRD_W    = 30;
   localparam int unsigned DEF_BIRD_H    = 30;
   localparam int unsigned DEF_BIRD_Y0   = 240;
   localparam int unsigned DEF_PIPE_W    = 50;
   localparam int unsigned DEF_GAP       = 180;
   localparam int unsigned DEF_PIPE_X0   = 590;
   localparam int unsigned DEF_PIPE_Y0   = 150;
   localparam int unsigned DEF_Y_MAX     = 450;
   localparam int unsigned DEF_FALL_STEP = 4;
   localparam int unsigned DEF_FLAP_STEP = 24;
   localparam int unsigned DEF_SCORE_W   = 4;

   localparam int unsigned PIPE_Y_BASE = 40;
   localparam logic [7:0]  LFSR_SEED   = 8'hA5;

   // Collision and physics arithmetic is done at this width so no sum can wrap.
   localparam int unsigned CALC_W = 11;
   typedef logic [CALC_W-1:0] calc_t;

   // x^8+x^6+x^5+x^4+1, Fibonacci form, shifting left.
   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

endpackage

// File: rtl/game_tick_div.sv
// Physics-step divider: counts 0..TICK_DIV-1 while enabled and flags the last
// count; clear has priority over counting.
module game_tick_div #(
   parameter int unsigned TICK_DIV = 250000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick_o = en_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/flappy_game_ctrl.sv
// Flappy-bird game sequencer: key decode, IDLE/RUN/DEAD control, bird/pipe
// physics at the divided tick rate and saturating score, all outputs registered.
module flappy_game_ctrl
   import flappy_pkg::*;
#(
   parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
   parameter int unsigned BIRD_X    = DEF_BIRD_X,
   parameter int unsigned BIRD_W    = DEF_BIRD_W,
   parameter int unsigned BIRD_H    = DEF_BIRD_H,
   parameter int unsigned BIRD_Y0   = DEF_BIRD_Y0,
   parameter int unsigned PIPE_W    = DEF_PIPE_W,
   parameter int unsigned GAP       = DEF_GAP,
   parameter int unsigned PIPE_X0   = DEF_PIPE_X0,
   parameter int unsigned PIPE_Y0   = DEF_PIPE_Y0,
   parameter int unsigned Y_MAX     = DEF_Y_MAX,
   parameter int unsigned FALL_STEP = DEF_FALL_STEP,
   parameter int unsigned FLAP_STEP = DEF_FLAP_STEP,
   parameter int unsigned SCORE_W   = DEF_SCORE_W
) (
   input  logic               iVGA_CLK,
   input  logic               rst,
   input  logic [7:0]         key_code,
   input  logic               key_valid,
   output logic [8:0]         bird_y,
   output logic [9:0]         pipe_x,
   output logic [8:0]         pipe_y,
   output logic [SCORE_W-1:0] score,
   output logic [1:0]         state,
   output logic               game_over,
   output logic               tick_o
);

   localparam calc_t C_BIRD_X   = calc_t'(BIRD_X);
   localparam calc_t C_BIRD_XR  = calc_t'(BIRD_X + BIRD_W);
   localparam calc_t C_BIRD_H   = calc_t'(BIRD_H);
   localparam calc_t C_PIPE_W   = calc_t'(PIPE_W);
   localparam calc_t C_GAP      = calc_t'(GAP);
   localparam calc_t C_Y_MAX    = calc_t'(Y_MAX);
   localparam calc_t C_FALL     = calc_t'(FALL_STEP);
   localparam logic [8:0] FLAP9 = 9'(FLAP_STEP);

   state_t               state_q, state_d;
   logic [8:0]           bird_y_q, bird_y_d;
   logic [9:0]           pipe_x_q, pipe_x_d;
   logic [8:0]           pipe_y_q, pipe_y_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic                 flap_q, flap_d;
   logic [7:0]           lfsr_q, lfsr_d;
   logic                 tick_q, tick_d;
   logic                 game_over_q, game_over_d;

   logic key_start, key_restart, key_flap;
   logic div_en, div_clr, div_tick;
   calc_t by_w, px_w, py_w;
   logic x_overlap, y_outside, loss, score_hit;
   logic [8:0] bird_up, bird_down;

   assign key_start   = key_valid && (key_code == KEY_START);
   assign key_restart = key_valid && (key_code == KEY_RESTART);
   assign key_flap    = key_valid && (key_code == KEY_FLAP);

   assign div_en  = (state_q == ST_RUN);
   assign div_clr = key_restart ||
                    (key_start && (state_q != ST_RUN) && (state_q != ST_DEAD));

   game_tick_div #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_div (
      .clk_i  (iVGA_CLK),
      .rst_i  (rst),
      .en_i   (div_en),
      .clr_i  (div_clr),
      .tick_o (div_tick)
   );

   assign by_w = calc_t'(bird_y_q);
   assign px_w = calc_t'(pipe_x_q);
   assign py_w = calc_t'(pipe_y_q);

   // Loss is judged on the pre-step positions; a losing step updates nothing.
   assign x_overlap = (px_w < C_BIRD_XR) && ((px_w + C_PIPE_W) > C_BIRD_X);
   assign y_outside = (by_w < py_w) || ((by_w + C_BIRD_H) > (py_w + C_GAP));
   assign loss      = (x_overlap && y_outside) || (by_w >= C_Y_MAX) || (by_w == '0);
   assign score_hit = ((px_w + C_PIPE_W) == C_BIRD_X);

   assign bird_up   = (bird_y_q >= FLAP9) ? (bird_y_q - FLAP9) : '0;
   assign bird_down = ((by_w + C_FALL) > C_Y_MAX) ? 9'(Y_MAX) : 9'(by_w + C_FALL);

   always_comb begin
      state_d  = state_q;
      bird_y_d = bird_y_q;
      pipe_x_d = pipe_x_q;
      pipe_y_d = pipe_y_q;
      score_d  = score_q;
      flap_d   = flap_q;
      lfsr_d   = lfsr_q;
      tick_d   = 1'b0;

      if (key_restart) begin
         state_d  = ST_IDLE;
         bird_y_d = 9'(BIRD_Y0);
         pipe_x_d = 10'(PIPE_X0);
         pipe_y_d = 9'(PIPE_Y0);
         score_d  = '0;
         flap_d   = 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (!div_tick) begin
                  flap_d = flap_q | key_flap;
               end else begin
                  tick_d = 1'b1;
                  if (loss) begin
                     state_d = ST_DEAD;
                  end else begin
                     bird_y_d = flap_q ? bird_up : bird_down;
                     // A flap arriving on the step cycle belongs to the next step.
                     flap_d   = key_flap;
                     if (pipe_x_q == '0) begin
                        pipe_x_d = 10'(PIPE_X0);
                        pipe_y_d = 9'(PIPE_Y_BASE) + {1'b0, lfsr_q};
                     end else begin
                        pipe_x_d = pipe_x_q - 10'd1;
                     end
                     if (score_hit && (score_q != '1)) begin
                        score_d = score_q + 1'b1;
                     end
                     lfsr_d = lfsr_next(lfsr_q);
                  end
               end
            end
            ST_DEAD: begin
            end
            default: begin
               if (key_start) begin
                  state_d = ST_RUN;
               end
            end
         endcase
      end

      game_over_d = (state_d == ST_DEAD);
   end

   always_ff @(posedge iVGA_CLK) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bird_y_q    <= 9'(BIRD_Y0);
         pipe_x_q    <= 10'(PIPE_X0);
         pipe_y_q    <= 9'(PIPE_Y0);
         score_q     <= '0;
         flap_q      <= 1'b0;
         lfsr_q      <= LFSR_SEED;
         tick_q      <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bird_y_q    <= bird_y_d;
         pipe_x_q    <= pipe_x_d;
         pipe_y_q    <= pipe_y_d;
         score_q     <= score_d;
         flap_q      <= flap_d;
         lfsr_q      <= lfsr_d;
         tick_q      <= tick_d;
         game_over_q <= game_over_d;
      end
   end

   assign bird_y    = bird_y_q;
   assign pipe_x    = pipe_x_q;
   assign pipe_y    = pipe_y_q;
   assign score     = score_q;
   assign state     = state_q;
   assign game_over = game_over_q;
   assign tick_o    = tick_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed-plus-random bench for flappy_game_ctrl against a behavioural game model.
module tb_flappy_game_ctrl;

   localparam int TD = 4;
   localparam logic [7:0] K_START   = 8'h51;
   localparam logic [7:0] K_RESTART = 8'h57;
   localparam logic [7:0] K_FLAP    = 8'h45;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] key_code = 8'h00;
   logic       key_valid = 1'b0;
   logic [8:0] bird_y;
   logic [9:0] pipe_x;
   logic [8:0] pipe_y;
   logic [3:0] score;
   logic [1:0] state;
   logic       game_over;
   logic       tick_o;

   flappy_game_ctrl #(.TICK_DIV(TD)) dut (
      .iVGA_CLK  (clk),
      .rst       (rst),
      .key_code  (key_code),
      .key_valid (key_valid),
      .bird_y    (bird_y),
      .pipe_x    (pipe_x),
      .pipe_y    (pipe_y),
      .score     (score),
      .state     (state),
      .game_over (game_over),
      .tick_o    (tick_o)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // game model: 0 idle, 1 running, 2 dead
   int m_state, m_by, m_px, m_py, m_score, m_cnt, m_lfsr;
   bit m_flap, m_tick;
   int m_passes = 0, m_resp = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input int exp);
      tests++;
      assert (obs === 32'(exp)) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
      if (fails >= 40) begin
         $display("[TB] %0d tests run, %0d failed", tests, fails);
         $finish;
      end
   endtask

   function automatic int lfsr_step(input int s);
      return ((s << 1) & 255) | ($countones(s & 'hB8) & 1);
   endfunction

   task automatic m_reload();
      m_state = 0; m_by = 240; m_px = 590; m_py = 150;
      m_score = 0; m_cnt = 0; m_flap = 0;
   endtask

   task automatic m_clock(input bit r, input bit v, input logic [7:0] c);
      bit restart, start, flap, hit, loss;
      restart = v && (c == K_RESTART);
      start   = v && (c == K_START);
      flap    = v && (c == K_FLAP);
      m_tick  = 0;
      if (r) begin
         m_reload();
         m_lfsr = 'hA5;
      end else if (restart) begin
         m_reload();
      end else if (m_state == 0) begin
         if (start) begin m_state = 1; m_cnt = 0; end
      end else if (m_state == 1) begin
         if (m_cnt != TD - 1) begin
            m_cnt++;
            if (flap) m_flap = 1;
         end else begin
            m_cnt  = 0;
            m_tick = 1;
            hit  = (m_px < 130) && (m_px + 50 > 100) && (m_by < m_py || m_by + 30 > m_py + 180);
            loss = hit || (m_by >= 450) || (m_by == 0);
            if (loss) m_state = 2;
            else begin
               if (m_px == 50) begin
                  m_passes++;
                  if (m_score < 15) m_score++;
               end
               m_by = m_flap ? ((m_by - 24 < 0) ? 0 : m_by - 24)
                             : ((m_by + 4 > 450) ? 450 : m_by + 4);
               if (m_px == 0) begin
                  m_px = 590; m_py = 40 + m_lfsr; m_resp++;
               end else m_px--;
               m_lfsr = lfsr_step(m_lfsr);
               m_flap = flap;
            end
         end
      end
   endtask

   task automatic cycle(input bit r, input bit v, input logic [7:0] c);
      rst = r; key_valid = v; key_code = c;
      @(posedge clk);
      m_clock(r, v, c);
      #1;
      chk("state", 32'(state), m_state);
      chk("game_over", 32'(game_over), (m_state == 2) ? 1 : 0);
      chk("tick_o", 32'(tick_o), int'(m_tick));
      chk("bird_y", 32'(bird_y), m_by);
      chk("pipe_x", 32'(pipe_x), m_px);
      chk("pipe_y", 32'(pipe_y), m_py);
      chk("score", 32'(score), m_score);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 8'($urandom));
   endtask

   // One physics window ending on its step cycle; assumes the divider just wrapped.
   task automatic step_with(input bit do_flap);
      if (do_flap) cycle(1'b0, 1'b1, K_FLAP); else idle();
      for (int i = 1; i < TD; i++) idle();
   endtask

   task automatic nav(input int need_pass, input int need_resp, input int budget);
      int p0, r0, n;
      bit v, want;
      logic [7:0] c;
      p0 = m_passes; r0 = m_resp; n = 0;
      while ((m_passes - p0 < need_pass || m_resp - r0 < need_resp) && n < budget) begin
         want = (m_by > m_py + 75) || (m_by > m_py + 40 && $urandom_range(0, 7) == 0);
         v = 0; c = 8'($urandom);
         if (m_cnt != TD - 1) begin
            if (want && !m_flap && (m_cnt == TD - 2 || $urandom_range(0, 1) == 1)) begin
               v = 1; c = K_FLAP;
            end else if (m_flap && $urandom_range(0, 3) == 0) begin
               v = 1; c = K_FLAP;
            end
         end
         if (!v && $urandom_range(0, 7) == 0) begin
            v = 1;
            c = ($urandom_range(0, 1) == 1) ? K_START : 8'($urandom);
            if (c == K_RESTART || c == K_FLAP) c = 8'h00;
         end
         cycle(1'b0, v, c);
         n++;
         if (game_over === 1'b1) break;
      end
      chk("nav_done", ((m_passes - p0 >= need_pass) && (m_resp - r0 >= need_resp)) ? 1 : 0, 1);
   endtask

   initial begin
      int ticks, last, k, px_before;
      logic [7:0] c;

      // reset and quiet idle
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00);
      ticks = 0;
      for (int i = 0; i < 100; i++) begin
         idle();
         ticks += int'(tick_o);
      end
      chk("idle_ticks", 32'(ticks), 0);
      chk("idle_bird", 32'(bird_y), 240);
      chk("idle_pipe_x", 32'(pipe_x), 590);

      // start, 40 cycles of free fall
      cycle(1'b0, 1'b1, K_START);
      ticks = 0; last = -1;
      for (int i = 1; i <= 40; i++) begin
         idle();
         if (tick_o === 1'b1) begin
            if (last >= 0) chk("tick_spacing", 32'(i - last), TD);
            last = i;
            ticks++;
         end
      end
      chk("run_ticks", 32'(ticks), 10);
      chk("run_bird", 32'(bird_y), 280);
      chk("run_pipe_x", 32'(pipe_x), 580);

      // three flaps in one window count once
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, K_FLAP);
      idle();
      chk("flap_once", 32'(bird_y), 256);
      step_with(1'b0);
      chk("fall_resume", 32'(bird_y), 260);
      for (int i = 0; i < TD - 1; i++) idle();
      cycle(1'b0, 1'b1, K_FLAP);
      chk("flap_on_step_deferred", 32'(bird_y), 264);
      step_with(1'b0);
      chk("flap_on_step_applied", 32'(bird_y), 240);

      // climb to 20, then 0, then die on the ceiling
      k = 0;
      while (m_by != 20 && k < 100) begin
         step_with(m_by >= 44);
         k++;
      end
      chk("bird_at_20", 32'(bird_y), 20);
      step_with(1'b1);
      chk("bird_clamped_0", 32'(bird_y), 0);
      px_before = int'(pipe_x);
      step_with(1'b0);
      chk("dead_state", 32'(state), 2);
      chk("dead_game_over", 32'(game_over), 1);
      chk("dead_bird_frozen", 32'(bird_y), 0);
      chk("dead_pipe_frozen", 32'(pipe_x), px_before);
      for (int i = 0; i < 30; i++) begin
         c = ($urandom_range(0, 1) == 1) ? K_START : K_FLAP;
         if ($urandom_range(0, 2) == 0) c = 8'($urandom);
         if (c == K_RESTART) c = 8'h00;
         cycle(1'b0, 1'($urandom), c);
      end
      chk("dead_still_frozen", 32'(pipe_x), px_before);

      // restart from dead; flap in idle is ignored
      cycle(1'b0, 1'b1, K_RESTART);
      chk("restart_state", 32'(state), 0);
      chk("restart_bird", 32'(bird_y), 240);
      chk("restart_pipe_y", 32'(pipe_y), 150);
      cycle(1'b0, 1'b1, K_FLAP);
      cycle(1'b0, 1'b1, K_START);
      step_with(1'b0);
      chk("idle_flap_ignored", 32'(bird_y), 244);

      // navigate: first score, respawn, then saturation
      nav(1, 0, 600 * TD);
      chk("first_score", 32'(score), 1);
      nav(0, 1, 60 * TD);
      chk("respawn_x", 32'(pipe_x), 590);
      chk("respawn_y_range", (pipe_y >= 9'd40 && pipe_y <= 9'd295) ? 32'd1 : 32'd0, 1);
      nav(15, 0, 15 * 600 * TD);
      chk("score_saturated", 32'(score), 15);

      // restart on the step cycle wins over the step
      k = 0;
      while (m_cnt != TD - 1 && k < TD) begin idle(); k++; end
      cycle(1'b0, 1'b1, K_RESTART);
      chk("restart_on_tick_state", 32'(state), 0);
      chk("restart_on_tick_tick", 32'(tick_o), 0);
      chk("restart_on_tick_score", 32'(score), 0);
      chk("restart_on_tick_pipe_x", 32'(pipe_x), 590);
      cycle(1'b0, 1'b1, K_START);
      nav(0, 1, 600 * TD);

      // synchronous reset mid-run reseeds the LFSR too
      cycle(1'b1, 1'b0, 8'h00);
      chk("rst_state", 32'(state), 0);
      chk("rst_bird", 32'(bird_y), 240);
      idle();
      cycle(1'b0, 1'b1, K_START);
      nav(0, 1, 600 * TD);
      chk("rst_respawn_y", 32'(pipe_y), 40 + 'hA5 == 0 ? 0 : m_py);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
